// File: rtl/alu_sequencer_if.sv
// Instruction-fetch handshake and ALU issue bus for alu_sequencer.
// The master view belongs to the sequencer; the slave view belongs to the
// environment, which supplies instructions and the combinational ALU.
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic [15:0]     Instr;
    logic            InstrValid;
    logic            InstrReady;
    logic [PC_W-1:0] PC;
    logic [15:0]     Operand1;
    logic [15:0]     Operand2;
    logic [2:0]      FUNC;
    logic [15:0]     Result;
    logic            ZF;

    modport master (
        input  Instr,
        input  InstrValid,
        input  Result,
        input  ZF,
        output InstrReady,
        output PC,
        output Operand1,
        output Operand2,
        output FUNC
    );

    modport slave (
        output Instr,
        output InstrValid,
        output Result,
        output ZF,
        input  InstrReady,
        input  PC,
        input  Operand1,
        input  Operand2,
        input  FUNC
    );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer for a 16-bit combinational ALU.
// Each instruction walks IDLE -> DECODE -> EXEC -> WB, so one instruction
// retires every four cycles. Operands come from an internal register file
// whose R0 is hardwired to zero; results are written back in WB together
// with the PC update. HALT parks the machine until reset.
module alu_sequencer #(
    parameter int PC_W = 8,
    parameter int NREG = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    alu_sequencer_if.master       bus,
    output logic                  Zflag,
    output logic                  Retire,
    output logic                  Halted,
    input  logic [2:0]            DbgSel,
    output logic [15:0]           DbgData
);

    localparam logic [3:0] OP_LI   = 4'b1000;
    localparam logic [3:0] OP_BZ   = 4'b1001;
    localparam logic [3:0] OP_HALT = 4'b1111;

    localparam logic [2:0] FUNC_ADD = 3'd0;
    localparam logic [2:0] FUNC_OR  = 3'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic [15:0]     r_instr;
    logic [15:0]     r_regs [NREG];
    logic [PC_W-1:0] r_pc;
    logic [15:0]     r_op1;
    logic [15:0]     r_op2;
    logic [2:0]      r_func;
    logic [15:0]     r_result;
    logic            r_zf;
    logic            r_zflag;

    logic            w_ready;
    logic            w_retire;
    logic            w_halted;

    logic [3:0]      w_opcode;
    logic [2:0]      w_rd;
    logic [2:0]      w_rs;
    logic [2:0]      w_rt;
    logic [5:0]      w_imm6;

    logic            w_is_alu;
    logic            w_is_li;
    logic            w_is_bz;
    logic            w_wb_en;

    logic [15:0]     w_dec_op1;
    logic [15:0]     w_dec_op2;
    logic [2:0]      w_dec_func;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_pc_br;
    logic [PC_W-1:0] w_pc_nxt;

    // Register-file read with R0 and out-of-range selects reading as zero.
    function automatic logic [15:0] rf_read(input logic [2:0] idx);
        logic [15:0] v;
        v = '0;
        if ((idx != 3'd0) && (int'(idx) < NREG)) begin
            v = r_regs[idx];
        end
        return v;
    endfunction

    // PC + 1 + sign-extended 6-bit offset, wrapping modulo 2^PC_W.
    function automatic logic [PC_W-1:0] branch_target(
        input logic [PC_W-1:0] pc,
        input logic [5:0]      imm
    );
        logic signed [5:0]      imm_s;
        logic signed [PC_W-1:0] off_s;
        imm_s = imm;
        off_s = {{(PC_W-6){imm_s[5]}}, imm_s};
        return pc + PC_W'(1) + $unsigned(off_s);
    endfunction

    assign w_opcode = r_instr[15:12];
    assign w_rd     = r_instr[11:9];
    assign w_rs     = r_instr[8:6];
    assign w_rt     = r_instr[5:3];
    assign w_imm6   = r_instr[5:0];

    assign w_is_alu = ~w_opcode[3];
    assign w_is_li  = (w_opcode == OP_LI);
    assign w_is_bz  = (w_opcode == OP_BZ);
    assign w_wb_en  = (w_is_alu || w_is_li) && (w_rd != 3'd0) && (int'(w_rd) < NREG);

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_pc_br  = branch_target(r_pc, w_imm6);
    assign w_pc_nxt = (w_is_bz && r_zf) ? w_pc_br : w_pc_inc;

    // Decode the latched instruction into the operand/function values for the ALU.
    always_comb begin
        w_dec_op1  = '0;
        w_dec_op2  = '0;
        w_dec_func = FUNC_ADD;
        if (w_is_alu) begin
            w_dec_op1  = rf_read(w_rs);
            w_dec_op2  = rf_read(w_rt);
            w_dec_func = w_opcode[2:0];
        end else if (w_is_li) begin
            w_dec_op2  = {10'd0, w_imm6};
        end else if (w_is_bz) begin
            w_dec_op1  = rf_read(w_rs);
            w_dec_op2  = rf_read(w_rs);
            w_dec_func = FUNC_OR;
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and status outputs; status is forced low while reset is held.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_retire    = 1'b0;
        w_halted    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_ready = ~RST;
                if (bus.InstrValid) begin
                    w_state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                w_state_nxt = (w_opcode == OP_HALT) ? S_HALTED : S_EXEC;
            end
            S_EXEC: begin
                w_state_nxt = S_WB;
            end
            S_WB: begin
                w_retire    = ~RST;
                w_state_nxt = S_IDLE;
            end
            S_HALTED: begin
                w_halted    = ~RST;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Instruction latch on acceptance and ALU result capture at the end of EXEC.
    always_ff @(posedge CLK) begin
        if ((r_state == S_IDLE) && bus.InstrValid) begin
            r_instr <= bus.Instr;
        end
        if (r_state == S_EXEC) begin
            r_result <= bus.Result;
            r_zf     <= bus.ZF;
        end
    end

    // Registered ALU issue bus, loaded only in DECODE and held until the next DECODE.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_op1  <= '0;
            r_op2  <= '0;
            r_func <= FUNC_ADD;
        end else if (r_state == S_DECODE) begin
            r_op1  <= w_dec_op1;
            r_op2  <= w_dec_op2;
            r_func <= w_dec_func;
        end
    end

    // Architectural state update in WB: register writeback, zero flag and PC.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_pc    <= '0;
            r_zflag <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == S_WB) begin
            r_pc <= w_pc_nxt;
            if (w_is_alu) begin
                r_zflag <= r_zf;
            end
            if (w_wb_en) begin
                r_regs[w_rd] <= r_result;
            end
        end
    end

    assign bus.InstrReady = w_ready;
    assign bus.PC         = r_pc;
    assign bus.Operand1   = r_op1;
    assign bus.Operand2   = r_op2;
    assign bus.FUNC       = r_func;

    assign Zflag   = r_zflag;
    assign Retire  = w_retire;
    assign Halted  = w_halted;
    assign DbgData = rf_read(DbgSel);

endmodule
